tv80_mem_arbiter: RTL
=====================

# tv80_mem_arbiter

Shares the single-port 64K×8 system memory between the tv80s CPU and a host/loader port. The host port preloads programs and reads back results at run time, replacing direct array pokes. The block takes the bus with the CPU's busrq_n/busak_n handshake, serves a bounded burst of host accesses, then hands the bus back. It sits between the CPU bus pins and the synchronous-read memory array.

## Interface
- ADDR_W, 16: address width (CPU, host and memory).
- DATA_W, 8: data width.
- MAX_BURST, 16: maximum number of host accesses per bus grant (at least 1).
- MIN_CPU, 4: minimum number of cycles the CPU owns the bus between grants (at least 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_a  in  ADDR_W  CPU address.
- cpu_do  in  DATA_W  CPU write data.
- cpu_di  out  DATA_W  CPU read data.
- cpu_mreq_n, cpu_rd_n, cpu_wr_n  in  1  CPU memory strobes.
- cpu_busrq_n  out  1  bus request to the CPU; registered.
- cpu_busak_n  in  1  bus acknowledge from the CPU.
- h_req  in  1  host access request; held until h_ack.
- h_we  in  1  1 = write, 0 = read.
- h_addr  in  ADDR_W  host address.
- h_wdata  in  DATA_W  host write data.
- h_ack  out  1  one-cycle completion pulse; registered.
- h_rdata  out  DATA_W  read data, valid while h_ack=1.
- mem_a  out  ADDR_W  memory address.
- mem_d  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable; the write commits at the next rising edge.
- mem_q  in  DATA_W  memory read data, valid one clock after mem_a is presented.
- owner  out  1  0 = CPU owns the memory, 1 = host owns it (HOST_ACC or HOST_ACK).

## Operation
States:
- CPU: the CPU owns the bus.
  - mem_a=cpu_a, mem_d=cpu_do, mem_we=~cpu_mreq_n&~cpu_wr_n, cpu_di=mem_q.
  - A gap counter counts up to MIN_CPU.
  - Go to REQ when h_req=1 and the gap counter has reached MIN_CPU.
  - busak_n low while in CPU (no request pending) is ignored.
- REQ: cpu_busrq_n=0. CPU routing is unchanged, because the CPU may finish its current cycle.
  - Go to HOST_ACC on sampling cpu_busak_n=0.
  - If h_req drops, go to REL (abort).
- HOST_ACC: mem_a=h_addr, mem_d=h_wdata, mem_we=h_we.
  - cpu_di is forced to 8'hFF.
  - The burst counter increments, and the state goes to HOST_ACK.
- HOST_ACK: mem_we=0, h_ack=1, h_rdata=mem_q (the value of the read issued in HOST_ACC).
  - Go to REL if h_req is low on the next edge or the burst counter equals MAX_BURST; otherwise go to HOST_ACC.
  - The host may drop h_req or change the address in the h_ack cycle.
- REL: cpu_busrq_n=1, mem_we=0.
  - Go to CPU on sampling cpu_busak_n=1; the gap counter and burst counter clear.

Additional rules:
- Host writes never occur outside HOST_ACC. CPU writes never occur outside CPU and REQ.
- h_req high with no grant is not an error; it waits.
- The burst counter is log2(MAX_BURST)+1 bits wide and saturates at MAX_BURST.
- Reset values: state=CPU, cpu_busrq_n=1, h_ack=0, h_rdata=0, counters=0, owner=0.
  - Combinational outputs follow CPU routing, so mem_we=0 while the CPU is idle.

## Timing
- Request: h_req is sampled high at edge k in CPU state with the gap expired. cpu_busrq_n goes low after edge k.
- Grant: cpu_busak_n is sampled low at edge m. HOST_ACC runs in cycle m→m+1, and the write commits at edge m+1. h_ack is high in cycle m+1→m+2.
- Throughput: one host access per 2 clocks.
- Release: cpu_busrq_n goes high 1 clock after the last h_ack. The CPU resumes when busak_n returns high.
- Re-request: no earlier than MIN_CPU cycles after entering CPU state.
- Reset: asserting reset_n in any state immediately returns all outputs to their reset values (asynchronous).
  - A HOST_ACC write in flight is dropped; mem_we falls combinationally.

## Test plan
- Reset: hold reset_n=0 for 3 clocks. Required: cpu_busrq_n=1, h_ack=0, owner=0, mem_we=0, h_rdata=00.
- CPU pass-through:
  - Setup: host preloads DD CB 92 97 at 0000, 23 at 840E, IX=847C, A=9A.
  - Required: after 23 CPU cycles, A=23, mem[840E]=23, PC=0004, R=02, and no busrq_n activity during execution.
- Host write burst while the CPU runs a NOP loop: host writes AA, 55, 0F to 1000–1002.
  - Required: busrq_n falls, exactly 3 h_ack pulses 2 clocks apart, then busrq_n rises.
  - Memory contents: mem[1000..1002]=AA,55,0F.
  - The CPU PC continues incrementing afterwards.
- Host read: read of 840E after the pass-through test. Required: h_rdata=23 with h_ack, and no write strobe.
- Burst limit: MAX_BURST=16, host requests 20 reads back-to-back.
  - Required: 16 acks, then a release, then the CPU owns the bus for at least 4 cycles with owner=0, then a re-grant and 4 more acks.
- Reset mid-burst: reset_n low during a HOST_ACC write of 77 to 2000.
  - Required: mem[2000] unchanged, busrq_n=1 immediately, h_ack=0, state CPU after release.

Source files
------------

// File: rtl/tv80_mem_arbiter.sv
// tv80_mem_arbiter: shares the single-port system memory between the tv80s
// CPU and a host/loader port using the CPU busrq_n/busak_n handshake.
`timescale 1ns/1ps
module tv80_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int MIN_CPU   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_do,
    output logic [DATA_W-1:0] cpu_di,
    input  logic              cpu_mreq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    output logic              cpu_busrq_n,
    input  logic              cpu_busak_n,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              owner
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int GW = $clog2(MIN_CPU + 1);

    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_CPU);

    localparam logic [2:0] S_CPU = 3'd0;
    localparam logic [2:0] S_REQ = 3'd1;
    localparam logic [2:0] S_ACC = 3'd2;
    localparam logic [2:0] S_ACK = 3'd3;
    localparam logic [2:0] S_REL = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          busrq_n_q, busrq_n_d;
    logic          h_ack_q, h_ack_d;
    logic          host_own;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        burst_d = burst_q;
        unique case (state_q)
            S_CPU: begin
                if (gap_q != GAP_MAX) begin
                    gap_d = gap_q + GW'(1);
                end
                if (h_req && gap_q == GAP_MAX) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // an abort wins over a simultaneous grant
                if (!h_req) begin
                    state_d = S_REL;
                end else if (!cpu_busak_n) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + BW'(1);
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!h_req || burst_q == BURST_MAX) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_REL: begin
                if (cpu_busak_n) begin
                    state_d = S_CPU;
                    gap_d   = '0;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    always_comb begin
        busrq_n_d = !(state_d == S_REQ || state_d == S_ACC ||
                      state_d == S_ACK);
        h_ack_d   = (state_d == S_ACK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CPU;
            gap_q     <= '0;
            burst_q   <= '0;
            busrq_n_q <= 1'b1;
            h_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            burst_q   <= burst_d;
            busrq_n_q <= busrq_n_d;
            h_ack_q   <= h_ack_d;
        end
    end

    assign host_own    = (state_q == S_ACC) || (state_q == S_ACK);
    assign owner       = host_own;
    assign cpu_busrq_n = busrq_n_q;
    assign h_ack       = h_ack_q;
    assign h_rdata     = h_ack_q ? mem_q : '0;

    always_comb begin
        mem_a  = cpu_a;
        mem_d  = cpu_do;
        mem_we = 1'b0;
        cpu_di = mem_q;
        unique case (state_q)
            S_CPU, S_REQ: begin
                mem_we = ~cpu_mreq_n & ~cpu_wr_n;
            end
            S_ACC: begin
                mem_a  = h_addr;
                mem_d  = h_wdata;
                mem_we = h_we;
                cpu_di = '1;
            end
            S_ACK: begin
                mem_a  = h_addr;
                mem_d  = h_wdata;
                cpu_di = '1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // read strobe carries no routing information for a sync-read array
    logic unused_rd;
    assign unused_rd = cpu_rd_n;

endmodule
